dark_mm: RTL and testbench
==========================

DARK_MM -- requirements
Module: dark_mm

Interface
REQ-001 Parameter TMO_CYCLES, default 0, sets the REQ-state cycles before abort; 0 disables the timeout.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 res  input  1  reset, asynchronous, active-high.
REQ-004 core_en  input  1  core requests an access (level).
REQ-005 core_rw  input  1  access direction: 1 = write, 0 = read.
REQ-006 core_addr  input  32  byte address.
REQ-007 core_be  input  4  byte enables, bit n selects byte lane n.
REQ-008 core_wdata  input  32  write data.
REQ-009 core_rdata  output  32  read data.
REQ-010 core_valid  output  1  one-cycle completion pulse.
REQ-011 core_err  output  1  error flag, qualified by core_valid.
REQ-012 daddr  output  32  memory-side address.
REQ-013 datao  output  32  memory-side write data.
REQ-014 wr  output  1  memory-side write strobe.
REQ-015 rd  output  1  memory-side read strobe.
REQ-016 be  output  4  memory-side byte enables.
REQ-017 datai  input  32  memory-side read data.
REQ-018 hlt  input  1  memory busy; transaction pending while high.

Function
REQ-019 FSM SHALL have states IDLE, REQ, DONE.
REQ-020 IDLE with core_en=1 SHALL capture core_addr, core_rw, core_be and core_wdata into registers at the clock edge and go to REQ.
REQ-021 In REQ, the outputs SHALL be: daddr/datao/be = captured values, wr = captured rw, rd = not captured rw; in IDLE and DONE, wr=rd=0.
REQ-022 REQ SHALL last at least one cycle.
REQ-023 REQ SHALL complete at the first edge with hlt=0; a read SHALL then register datai into core_rdata, and the FSM SHALL go to DONE.
REQ-024 DONE SHALL assert core_valid=1 for exactly one cycle and then return to IDLE.
REQ-025 core_rdata SHALL hold its value until the next read completion; writes SHALL not change it.
REQ-026 Core input changes during REQ or DONE SHALL be ignored, because all inputs are captured at request time.
REQ-027 If core_en is still high in IDLE after DONE, a new transaction SHALL start; the minimum turnaround is 3 cycles per access.
REQ-028 With TMO_CYCLES=N>0, if hlt remains high for N consecutive REQ cycles: abort (wr=rd=0), go to DONE, core_err=1 with core_valid, core_rdata unchanged.
REQ-029 core_err SHALL be 0 whenever core_valid=0.

Reset
REQ-030 res=1 SHALL immediately force the FSM to IDLE.
REQ-031 res=1 SHALL immediately set core_valid, core_err, wr, rd, be, daddr, datao, core_rdata and the timeout counter to 0.
REQ-032 Reset during REQ SHALL drop wr/rd asynchronously; no completion pulse SHALL follow.

Configuration
REQ-033 Macro DARKMM_BE_CHECK_EN SHALL gate byte-enable checking.
REQ-034 With DARKMM_BE_CHECK_EN defined, a request with be=0000, a non-contiguous be (e.g. 0101), or be misaligned to addr[1:0] SHALL skip REQ and go straight to DONE with core_err=1.
REQ-035 Misaligned be means the lowest set be bit is below addr[1:0], or a halfword/word lane spills past lane 3.
REQ-036 Without DARKMM_BE_CHECK_EN, all be values SHALL pass unchanged and core_err SHALL arise only from timeout.

Structure
REQ-037 Shared package dark_pkg SHALL hold the FSM state enum (IDLE/REQ/DONE), the 32-bit data and address widths, and the 4-bit be width.
REQ-038 The design SHALL be a single module with no sub-modules; the be-legality check is a function in dark_pkg.

Verification
REQ-039 Read: core_en=1, rw=0, addr=0x10, be=1111, hlt low throughout -> rd=1 for 1 cycle, core_valid on the next cycle, core_rdata = datai (0xDEADBEEF).
REQ-040 Write: rw=1, addr=0x24, wdata=0x12345678, be=0011, hlt high 3 cycles -> wr held 4 cycles with daddr=0x24, datao=0x12345678, be=0011; core_valid after hlt falls.
REQ-041 Back-to-back: core_en held for 2 reads -> two core_valid pulses 3 cycles apart, each core_rdata matching its datai.
REQ-042 Timeout: TMO_CYCLES=8, hlt stuck high -> core_valid with core_err=1 after 8 REQ cycles, wr=rd=0, core_rdata unchanged.
REQ-043 Reset mid-REQ: assert res with rd=1 -> rd=0 immediately, no core_valid, FSM in IDLE.
REQ-044 DARKMM_BE_CHECK_EN: be=0101 -> no rd/wr issued, core_valid with core_err=1 on the next cycle; with the macro off, the same request completes normally.

Source files
------------

// File: rtl/dark_pkg.sv
// Shared types and widths for the dark_mm memory master, plus the byte-enable
// legality check used when DARKMM_BE_CHECK_EN is defined.
package dark_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal: non-empty, one contiguous run of lanes, starting at or above the
  // address offset, and not running past the top lane from that offset.
  function automatic logic be_legal(input logic [BE_W-1:0] be_v,
                                    input logic [1:0]      off);
    int lo;
    int n;
    logic [BE_W-1:0] run;
    lo = 0;
    n  = 0;
    for (int i = BE_W - 1; i >= 0; i--) begin
      if (be_v[i]) lo = i;
    end
    for (int i = 0; i < BE_W; i++) begin
      if (be_v[i]) n = n + 1;
    end
    run = BE_W'(((1 << n) - 1) << lo);
    if (be_v == '0)               return 1'b0;
    if (be_v != run)              return 1'b0;
    if (lo < int'(off))           return 1'b0;
    if (int'(off) + n > BE_W)     return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/dark_mm_if.sv
// Core-side request/response bus of dark_mm; the core is the master, the
// memory master block is the slave.
interface dark_mm_if;
  import dark_pkg::*;

  logic              core_en;
  logic              core_rw;
  logic [ADDR_W-1:0] core_addr;
  logic [BE_W-1:0]   core_be;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_valid;
  logic              core_err;

  modport master (
    output core_en, core_rw, core_addr, core_be, core_wdata,
    input  core_rdata, core_valid, core_err
  );

  modport slave (
    input  core_en, core_rw, core_addr, core_be, core_wdata,
    output core_rdata, core_valid, core_err
  );

endinterface

// File: rtl/dark_mm.sv
// Single-access memory master: IDLE -> REQ (until hlt low or timeout) -> DONE.
// Define DARKMM_BE_CHECK_EN to reject illegal byte-enable patterns up front.
module dark_mm
  import dark_pkg::*;
#(
  parameter int TMO_CYCLES = 0
) (
  input  logic              clk,
  input  logic              res,
  dark_mm_if.slave          core,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] datao,
  output logic              wr,
  output logic              rd,
  output logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] datai,
  input  logic              hlt
);

  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rw_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [TW-1:0]     tmo_cnt;
  logic              be_ok;
  logic              tmo_hit;

`ifdef DARKMM_BE_CHECK_EN
  assign be_ok = be_legal(core.core_be, core.core_addr[1:0]);
`else
  assign be_ok = 1'b1;
`endif

  // The Nth consecutive busy REQ cycle ends the access instead of waiting on.
  assign tmo_hit = (TMO_CYCLES > 0) && hlt && (tmo_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core.core_en) begin
            addr_q  <= core.core_addr;
            wdata_q <= core.core_wdata;
            be_q    <= core.core_be;
            rw_q    <= core.core_rw;
            tmo_cnt <= '0;
            err_q   <= ~be_ok;
            state   <= be_ok ? REQ : DONE;
          end
        end
        REQ: begin
          if (!hlt) begin
            if (!rw_q) rdata_q <= datai;
            state <= DONE;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and the completion pulse decode straight from state so that an
  // asynchronous reset removes them without waiting for a clock.
  assign wr              = (state == REQ) &  rw_q;
  assign rd              = (state == REQ) & ~rw_q;
  assign daddr           = addr_q;
  assign datao           = wdata_q;
  assign be              = be_q;
  assign core.core_rdata = rdata_q;
  assign core.core_valid = (state == DONE);
  assign core.core_err   = (state == DONE) & err_q;

endmodule

// File: tb/tb_dark_mm.sv
// Directed bench for dark_mm with an 8-cycle timeout.
module tb_dark_mm;

  logic        clk;
  logic        res;
  logic [31:0] daddr;
  logic [31:0] datao;
  logic        wr;
  logic        rd;
  logic [3:0]  be;
  logic [31:0] datai;
  logic        hlt;

  int n_chk;
  int n_pass;

  dark_mm_if cif ();

  dark_mm #(.TMO_CYCLES(8)) dut (
    .clk   (clk),
    .res   (res),
    .core  (cif),
    .daddr (daddr),
    .datao (datao),
    .wr    (wr),
    .rd    (rd),
    .be    (be),
    .datai (datai),
    .hlt   (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rw, input logic [31:0] addr, input logic [3:0] bev,
                     input logic [31:0] wdata);
    cif.core_en    = 1'b1;
    cif.core_rw    = rw;
    cif.core_addr  = addr;
    cif.core_be    = bev;
    cif.core_wdata = wdata;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    res    = 1'b1;
    hlt    = 1'b0;
    datai  = 32'h0;
    cif.core_en    = 1'b0;
    cif.core_rw    = 1'b0;
    cif.core_addr  = 32'h0;
    cif.core_be    = 4'h0;
    cif.core_wdata = 32'h0;

    // reset state, observed before any clock edge
    #3;
    check("rst_valid", {31'd0, cif.core_valid}, 32'd0);
    check("rst_err",   {31'd0, cif.core_err},   32'd0);
    check("rst_wr",    {31'd0, wr},             32'd0);
    check("rst_rd",    {31'd0, rd},             32'd0);
    check("rst_be",    {28'd0, be},             32'd0);
    check("rst_daddr", daddr,                   32'd0);
    check("rst_datao", datao,                   32'd0);
    check("rst_rdata", cif.core_rdata,          32'd0);
    tick();
    res = 1'b0;
    tick();
    check("idle_rd", {31'd0, rd}, 32'd0);

    // single read, memory ready
    req(1'b0, 32'h10, 4'hF, 32'h0);
    datai = 32'hDEADBEEF;
    tick();
    cif.core_en = 1'b0;
    check("rd_strobe", {31'd0, rd}, 32'd1);
    check("rd_wr",     {31'd0, wr}, 32'd0);
    check("rd_daddr",  daddr,       32'h10);
    check("rd_be",     {28'd0, be}, 32'hF);
    check("rd_novalid", {31'd0, cif.core_valid}, 32'd0);
    tick();
    check("rd_valid",  {31'd0, cif.core_valid}, 32'd1);
    check("rd_err",    {31'd0, cif.core_err},   32'd0);
    check("rd_rd_off", {31'd0, rd},             32'd0);
    check("rd_rdata",  cif.core_rdata,          32'hDEADBEEF);
    tick();
    check("rd_pulse1", {31'd0, cif.core_valid}, 32'd0);

    // write with hlt high for 3 REQ cycles; core inputs wiggle meanwhile
    req(1'b1, 32'h24, 4'h3, 32'h12345678);
    hlt   = 1'b1;
    datai = 32'hCAFEF00D;
    tick();
    cif.core_en    = 1'b0;
    cif.core_addr  = 32'hFFFF_0000;
    cif.core_wdata = 32'h0BAD0BAD;
    cif.core_be    = 4'hC;
    for (int i = 0; i < 3; i++) begin
      check("wr_held",   {31'd0, wr}, 32'd1);
      check("wr_daddr",  daddr,       32'h24);
      check("wr_novalid", {31'd0, cif.core_valid}, 32'd0);
      tick();
    end
    hlt = 1'b0;
    check("wr_held4", {31'd0, wr}, 32'd1);
    check("wr_datao", datao,       32'h12345678);
    check("wr_be",    {28'd0, be}, 32'h3);
    check("wr_rd",    {31'd0, rd}, 32'd0);
    tick();
    check("wr_valid", {31'd0, cif.core_valid}, 32'd1);
    check("wr_err",   {31'd0, cif.core_err},   32'd0);
    check("wr_wr_off", {31'd0, wr},            32'd0);
    check("wr_rdata_kept", cif.core_rdata,     32'hDEADBEEF);
    tick();

    // back-to-back reads, core_en held: valid pulses 3 cycles apart
    req(1'b0, 32'h40, 4'hF, 32'h0);
    datai = 32'h11111111;
    tick();
    check("b2b_rd1", {31'd0, rd}, 32'd1);
    tick();
    check("b2b_valid1", {31'd0, cif.core_valid}, 32'd1);
    check("b2b_rdata1", cif.core_rdata,          32'h11111111);
    datai = 32'h22222222;
    tick();
    check("b2b_idle_valid", {31'd0, cif.core_valid}, 32'd0);
    check("b2b_idle_rd",    {31'd0, rd},             32'd0);
    tick();
    cif.core_en = 1'b0;
    check("b2b_rd2",    {31'd0, rd},             32'd1);
    check("b2b_req_valid", {31'd0, cif.core_valid}, 32'd0);
    tick();
    check("b2b_valid2", {31'd0, cif.core_valid}, 32'd1);
    check("b2b_rdata2", cif.core_rdata,          32'h22222222);
    tick();

    // timeout: hlt stuck high for 8 REQ cycles
    req(1'b0, 32'h50, 4'hF, 32'h0);
    datai = 32'h99999999;
    hlt   = 1'b1;
    tick();
    cif.core_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("tmo_rd_held", {31'd0, rd},             32'd1);
      check("tmo_novalid", {31'd0, cif.core_valid}, 32'd0);
      tick();
    end
    check("tmo_valid", {31'd0, cif.core_valid}, 32'd1);
    check("tmo_err",   {31'd0, cif.core_err},   32'd1);
    check("tmo_rd",    {31'd0, rd},             32'd0);
    check("tmo_wr",    {31'd0, wr},             32'd0);
    check("tmo_rdata", cif.core_rdata,          32'h22222222);
    hlt = 1'b0;
    tick();
    check("tmo_err_clr", {31'd0, cif.core_err}, 32'd0);

    // one cycle short of the timeout: completes normally
    req(1'b0, 32'h60, 4'hF, 32'h0);
    datai = 32'h77777777;
    hlt   = 1'b1;
    tick();
    cif.core_en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    hlt = 1'b0;
    check("tmo7_rd", {31'd0, rd}, 32'd1);
    tick();
    check("tmo7_valid", {31'd0, cif.core_valid}, 32'd1);
    check("tmo7_err",   {31'd0, cif.core_err},   32'd0);
    check("tmo7_rdata", cif.core_rdata,          32'h77777777);
    tick();

    // reset in the middle of a read REQ
    req(1'b0, 32'h70, 4'hF, 32'h0);
    hlt = 1'b1;
    tick();
    cif.core_en = 1'b0;
    check("mid_rd_before", {31'd0, rd}, 32'd1);
    #2;
    res = 1'b1;
    #1;
    check("mid_rd_async",  {31'd0, rd}, 32'd0);
    check("mid_daddr",     daddr,       32'd0);
    check("mid_rdata",     cif.core_rdata, 32'd0);
    #2;
    res = 1'b0;
    hlt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_novalid", {31'd0, cif.core_valid}, 32'd0);
      check("mid_nord",    {31'd0, rd},             32'd0);
    end

    // non-contiguous byte enables
    req(1'b0, 32'h0, 4'h5, 32'h0);
    datai = 32'hABCD0123;
    tick();
    cif.core_en = 1'b0;
`ifdef DARKMM_BE_CHECK_EN
    check("be5_rd",    {31'd0, rd},             32'd0);
    check("be5_wr",    {31'd0, wr},             32'd0);
    check("be5_valid", {31'd0, cif.core_valid}, 32'd1);
    check("be5_err",   {31'd0, cif.core_err},   32'd1);
    check("be5_rdata", cif.core_rdata,          32'd0);
`else
    check("be5_rd",    {31'd0, rd},             32'd1);
    check("be5_be",    {28'd0, be},             32'h5);
    tick();
    check("be5_valid", {31'd0, cif.core_valid}, 32'd1);
    check("be5_err",   {31'd0, cif.core_err},   32'd0);
    check("be5_rdata", cif.core_rdata,          32'hABCD0123);
`endif
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
